// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arbiter
//  Brief    : Two-port arbiter/sequencer in front of the single-port data
//             memory. Port 0 is the CPU load/store unit and port 1 is the
//             debug/DMA loader. Each access runs IDLE -> MEM -> RESP, giving
//             one access every three cycles. Out-of-range addresses are
//             flagged and never reach the memory as writes.
//  Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
  parameter int DEPTH = 32,  // implemented memory words; addr >= DEPTH is an error
  parameter int RR    = 1    // 1 = round-robin, 0 = fixed priority (port 0 wins)
) (
  input  logic        clk,
  input  logic        rst_n,

  // Port 0 (CPU load/store unit)
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [11:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,

  // Port 1 (debug / DMA loader)
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [11:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,

  // Data memory side
  output logic        we_DM,
  output logic [11:0] addDM,
  output logic [31:0] dataDM,
  input  logic [31:0] outDM,

  output logic        busy
);

  // A 12-bit address can never reach 4096, so larger depths simply
  // disable the range error.
  localparam logic [12:0] c_DEPTH_LIM = (DEPTH >= 4096) ? 13'd4096 : 13'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cmd_we;
  logic [11:0] r_cmd_addr;
  logic [31:0] r_cmd_wdata;
  logic        r_cmd_err;
  logic        r_gnt;
  logic        r_last_gnt;

  logic        w_any;
  logic        w_sel;
  logic        w_accept;
  logic        w_req_we;
  logic [11:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        w_req_err;
  logic [31:0] w_rsp_rdata;

  // Arbitration: pick the requesting port; on contention either alternate
  // against the last grant or let port 0 win.
  always_comb begin
    w_any = p0_req_valid | p1_req_valid;
    w_sel = 1'b0;
    if (p0_req_valid && p1_req_valid) begin
      w_sel = (RR != 0) ? ~r_last_gnt : 1'b0;
    end else if (p1_req_valid) begin
      w_sel = 1'b1;
    end
  end

  // Ready is held low while reset is asserted so no requester sees a
  // handshake that the state registers are about to discard.
  assign w_accept     = (r_state == ST_IDLE) && rst_n && w_any;
  assign p0_req_ready = w_accept && !w_sel;
  assign p1_req_ready = w_accept &&  w_sel;

  // Request payload of the selected port and its range check.
  assign w_req_we    = w_sel ? p1_req_we    : p0_req_we;
  assign w_req_addr  = w_sel ? p1_req_addr  : p0_req_addr;
  assign w_req_wdata = w_sel ? p1_req_wdata : p0_req_wdata;
  assign w_req_err   = ({1'b0, w_req_addr} >= c_DEPTH_LIM);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command capture on accept; the memory address/data buses are driven
  // straight from these so they stay quiet between accesses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= 12'd0;
      r_cmd_wdata <= 32'd0;
      r_cmd_err   <= 1'b0;
      r_gnt       <= 1'b0;
      r_last_gnt  <= 1'b1;
    end else if (w_accept) begin
      r_cmd_we    <= w_req_we;
      r_cmd_addr  <= w_req_addr;
      r_cmd_wdata <= w_req_wdata;
      r_cmd_err   <= w_req_err;
      r_gnt       <= w_sel;
      r_last_gnt  <= w_sel;
    end
  end

  // Read data is only meaningful for an in-range read; everything else
  // returns zero.
  assign w_rsp_rdata = (!r_cmd_we && !r_cmd_err) ? outDM : 32'd0;

  // Next-state and per-state outputs. we_DM is deliberately not gated by
  // reset: a write sitting in MEM completes even if reset hits that edge.
  always_comb begin
    w_state_nxt  = r_state;
    we_DM        = 1'b0;
    p0_rsp_valid = 1'b0;
    p0_rsp_rdata = 32'd0;
    p0_rsp_err   = 1'b0;
    p1_rsp_valid = 1'b0;
    p1_rsp_rdata = 32'd0;
    p1_rsp_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_MEM;
        end
      end
      ST_MEM: begin
        we_DM       = r_cmd_we && !r_cmd_err;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (r_gnt) begin
          p1_rsp_valid = 1'b1;
          p1_rsp_rdata = w_rsp_rdata;
          p1_rsp_err   = r_cmd_err;
        end else begin
          p0_rsp_valid = 1'b1;
          p0_rsp_rdata = w_rsp_rdata;
          p0_rsp_err   = r_cmd_err;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign addDM  = r_cmd_addr;
  assign dataDM = r_cmd_wdata;
  assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_arbiter
//  Brief    : Directed self-checking bench for dm_arbiter. A behavioural
//             registered-read memory stands in for datamem. A second
//             instance with fixed priority shows port 1 starving.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [11:0] p0_req_addr;
  logic [31:0] p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [11:0] p1_req_addr;
  logic [31:0] p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;
  logic        we_DM, busy;
  logic [11:0] addDM;
  logic [31:0] dataDM;
  logic [31:0] outDM;

  // Fixed-priority instance signals
  logic        fp_v0, fp_v1;
  logic        fp_p0_ready, fp_p1_ready;
  logic        fp_p0_rsp_valid, fp_p1_rsp_valid, fp_p0_rsp_err, fp_p1_rsp_err;
  logic [31:0] fp_p0_rsp_rdata, fp_p1_rsp_rdata;
  logic        fp_we_DM, fp_busy;
  logic [11:0] fp_addDM;
  logic [31:0] fp_dataDM;

  logic [31:0] mem [0:4095];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.DEPTH(32), .RR(1)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_req_we    (p0_req_we),
    .p0_req_addr  (p0_req_addr),
    .p0_req_wdata (p0_req_wdata),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p0_rsp_err   (p0_rsp_err),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_req_we    (p1_req_we),
    .p1_req_addr  (p1_req_addr),
    .p1_req_wdata (p1_req_wdata),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_rdata (p1_rsp_rdata),
    .p1_rsp_err   (p1_rsp_err),
    .we_DM        (we_DM),
    .addDM        (addDM),
    .dataDM       (dataDM),
    .outDM        (outDM),
    .busy         (busy)
  );

  dm_arbiter #(.DEPTH(32), .RR(0)) u_dut_fp (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req_valid (fp_v0),
    .p0_req_ready (fp_p0_ready),
    .p0_req_we    (1'b0),
    .p0_req_addr  (12'h000),
    .p0_req_wdata (32'd0),
    .p0_rsp_valid (fp_p0_rsp_valid),
    .p0_rsp_rdata (fp_p0_rsp_rdata),
    .p0_rsp_err   (fp_p0_rsp_err),
    .p1_req_valid (fp_v1),
    .p1_req_ready (fp_p1_ready),
    .p1_req_we    (1'b0),
    .p1_req_addr  (12'h001),
    .p1_req_wdata (32'd0),
    .p1_rsp_valid (fp_p1_rsp_valid),
    .p1_rsp_rdata (fp_p1_rsp_rdata),
    .p1_rsp_err   (fp_p1_rsp_err),
    .we_DM        (fp_we_DM),
    .addDM        (fp_addDM),
    .dataDM       (fp_dataDM),
    .outDM        (32'd0),
    .busy         (fp_busy)
  );

  // Behavioural datamem: synchronous write, registered read.
  always @(posedge clk) begin
    if (we_DM) mem[addDM] <= dataDM;
    outDM <= mem[addDM];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access on a single port; starts and ends just after a
  // falling edge with the arbiter idle.
  task automatic xact(input int p, input logic we, input logic [11:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
    logic exp_we;
    exp_we = we && (a < 12'd32);
    if (p == 0) begin
      p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    end else begin
      p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    end
    #1;
    chk({tag, " ready"}, 32'((p == 0) ? p0_req_ready : p1_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    #1;
    chk({tag, " mem busy"}, 32'(busy), 32'd1);
    chk({tag, " mem we_DM"}, 32'(we_DM), 32'(exp_we));
    chk({tag, " mem addDM"}, 32'(addDM), 32'(a));
    if (we) chk({tag, " mem dataDM"}, dataDM, d);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, " rsp valid"}, 32'((p == 0) ? p0_rsp_valid : p1_rsp_valid), 32'd1);
    chk({tag, " other rsp"}, 32'((p == 0) ? p1_rsp_valid : p0_rsp_valid), 32'd0);
    chk({tag, " rdata"}, (p == 0) ? p0_rsp_rdata : p1_rsp_rdata, exp_rd);
    chk({tag, " err"}, 32'((p == 0) ? p0_rsp_err : p1_rsp_err), 32'(exp_err));
    chk({tag, " resp we_DM"}, 32'(we_DM), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    outDM = 32'd0;
    fp_v0 = 1'b0; fp_v1 = 1'b0;
    rst_n = 1'b0;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 12'h000; p0_req_wdata = 32'd0;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 12'h001; p1_req_wdata = 32'd0;

    // Reset held three cycles with both ports requesting
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst p0_ready", 32'(p0_req_ready), 32'd0);
      chk("rst p1_ready", 32'(p1_req_ready), 32'd0);
      chk("rst busy",     32'(busy),         32'd0);
      chk("rst we_DM",    32'(we_DM),        32'd0);
      chk("rst rsp",      32'({p0_rsp_valid, p1_rsp_valid}), 32'd0);
      chk("rst addDM",    32'(addDM),        32'd0);
    end
    rst_n = 1'b1;

    // Round-robin under continuous contention: grants 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr p0_ready", 32'(p0_req_ready), 32'((i % 2) == 0));
      chk("rr p1_ready", 32'(p1_req_ready), 32'((i % 2) == 1));
      @(posedge clk);
      @(negedge clk);
      if (i == 3) p1_req_valid = 1'b0;
      #1;
      chk("rr busy", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rr p0_rsp", 32'(p0_rsp_valid), 32'((i % 2) == 0));
      chk("rr p1_rsp", 32'(p1_rsp_valid), 32'((i % 2) == 1));
      chk("rr rdata", (i % 2 == 0) ? p0_rsp_rdata : p1_rsp_rdata, 32'd0);
      @(negedge clk);
    end
    // Port 0 still holds its pending request; drain it
    #1;
    chk("drain p0_ready", 32'(p0_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    p0_req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain p0_rsp", 32'(p0_rsp_valid), 32'd1);
    @(negedge clk);
    #1;
    chk("idle busy", 32'(busy), 32'd0);

    // Port 0 write then read back
    xact(0, 1'b1, 12'h005, 32'h0000_1DFE, 32'd0,          1'b0, "p0 wr5");
    xact(0, 1'b0, 12'h005, 32'd0,         32'h0000_1DFE, 1'b0, "p0 rd5");

    // Out-of-range write must not disturb addr 0
    xact(0, 1'b1, 12'h000, 32'h0000_0A0A, 32'd0,          1'b0, "p0 wr0");
    xact(1, 1'b1, 12'h020, 32'hFFFF_FFFF, 32'd0,          1'b1, "p1 oor");
    xact(0, 1'b0, 12'h000, 32'd0,         32'h0000_0A0A, 1'b0, "p0 rd0");
    xact(1, 1'b0, 12'h01F, 32'd0,         32'd0,          1'b0, "p1 rd31");

    // Cross-port coherency
    xact(1, 1'b1, 12'h001, 32'h0000_1001, 32'd0,          1'b0, "p1 wr1");
    xact(0, 1'b0, 12'h001, 32'd0,         32'h0000_1001, 1'b0, "p0 rd1");

    // Reset asserted while a write sits in MEM
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 12'h003; p0_req_wdata = 32'h0000_ABCD;
    #1;
    chk("mid ready", 32'(p0_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    p0_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid we_DM", 32'(we_DM), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid rsp", 32'({p0_rsp_valid, p1_rsp_valid}), 32'd0);
    chk("mid busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    xact(0, 1'b0, 12'h003, 32'd0, 32'h0000_ABCD, 1'b0, "p0 rd3");

    // Fixed priority: port 0 wins every time, port 1 starves
    fp_v0 = 1'b1;
    fp_v1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp p0_ready", 32'(fp_p0_ready), 32'd1);
      chk("fp p1_ready", 32'(fp_p1_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("fp p0_rsp", 32'(fp_p0_rsp_valid), 32'd1);
      chk("fp p1_rsp", 32'(fp_p1_rsp_valid), 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
